ddr_rx_align_ctrl: RTL and testbench
====================================

DDR_RX_ALIGN_CTRL -- requirements
Module: ddr_rx_align_ctrl

Interface
REQ-001 SHALL have parameter PAD_WIDTH, default 8: lane width of the DDR input capture pair.
REQ-002 SHALL have parameter SYNC_PAT, default 16'hF628 (width 2*PAD_WIDTH): frame alignment word.
REQ-003 SHALL have parameter FRAME_LEN, default 1024: frame period in inclock cycles, range 4..65535.
REQ-004 SHALL have parameter VERIFY_N, default 2, and LOSS_N, default 4: consecutive hits to lock and consecutive misses to drop lock, range 1..15.
REQ-005 SHALL use one clock and an asynchronous active-low reset, with ports as follows: inclock  in  1  capture clock; every register is clocked on its rising edge.
REQ-006 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have: en  in  1  search enable; 0 forces HUNT and idle outputs.
REQ-008 SHALL have: resync  in  1  single-cycle pulse that forces re-acquisition.
REQ-009 SHALL have: ddr_h  in  PAD_WIDTH  rising-edge sample from the DDR capture.
REQ-010 SHALL have: ddr_l  in  PAD_WIDTH  falling-edge sample from the DDR capture, re-timed to the rising edge; it is earlier in time than ddr_h of the same cycle.
REQ-011 SHALL have: data_out  out  2*PAD_WIDTH  aligned word, earliest bit in MSB.
REQ-012 SHALL have: data_vld  out  1  data_out valid; high only in LOCK.
REQ-013 SHALL have: sof  out  1  data_out holds SYNC_PAT at the frame position.
REQ-014 SHALL have: lock  out  1  state is LOCK.
REQ-015 SHALL have: phase  out  1  selected pairing, 0 = {ddr_l,ddr_h} and 1 = {h_d1,ddr_l}.
REQ-016 SHALL have: err_cnt  out  8  saturating count of missed sync words while locked.

Function
REQ-017 SHALL register h_d1 <= ddr_h every cycle and form w0 = {ddr_l, ddr_h} and w1 = {h_d1, ddr_l}.
REQ-018 SHALL implement the states HUNT, VERIFY and LOCK, plus a frame counter fcnt (0..FRAME_LEN-1), hit counter hcnt and miss counter mcnt.
REQ-019 In HUNT, if w0==SYNC_PAT the block SHALL set phase=0, fcnt=1, hcnt=0 and go to VERIFY. Else, if w1==SYNC_PAT, it SHALL do the same with phase=1. w0 has priority when both match.
REQ-020 Outside HUNT, fcnt SHALL increment every cycle and wrap from FRAME_LEN-1 to 0; fcnt==0 is the expected sync position ("checkpoint").
REQ-021 At a VERIFY checkpoint, if the selected word matches, hcnt SHALL increment and the state SHALL go to LOCK when hcnt+1==VERIFY_N. A mismatch SHALL send the state to HUNT.
REQ-022 At a LOCK checkpoint, a match SHALL clear mcnt. A mismatch SHALL increment mcnt and err_cnt (err_cnt saturates at 255), and SHALL send the state to HUNT when mcnt+1==LOSS_N.
REQ-023 Off-checkpoint cycles SHALL never change state, phase, hcnt or mcnt, even if SYNC_PAT appears.
REQ-024 data_out SHALL be the selected-phase word registered once, giving 1-cycle latency. Outside LOCK, data_out SHALL hold 0.
REQ-025 data_vld and lock SHALL both be high exactly while the state is LOCK, aligned with data_out.
REQ-026 sof SHALL pulse for one cycle, aligned with data_out, for a LOCK checkpoint match.
REQ-027 On the LOCK checkpoint that causes loss, the mismatching word SHALL still be output with data_vld=1 and sof=0; data_vld SHALL fall on the next cycle.
REQ-028 resync=1 or en=0 SHALL force HUNT on the next edge and clear fcnt, hcnt and mcnt; phase and err_cnt SHALL be held. This takes priority over all checkpoint actions.
REQ-029 With en=0, no HUNT search SHALL occur.
REQ-030 err_cnt SHALL clear only on reset.

Reset
REQ-031 On rst_n=0 the block SHALL asynchronously set: state HUNT; fcnt, hcnt, mcnt, h_d1, data_out and err_cnt 0; data_vld, sof, lock and phase 0.
REQ-032 After rst_n deasserts, the block SHALL act from the first rising edge.

Verification
REQ-033 Phase 0 acquisition: SYNC_PAT in {l,h} every 1024 cycles, defaults -> lock=1 at the 2nd checkpoint after first detection, phase=0, sof every 1024 cycles, data_out==16'hF628 when sof=1.
REQ-034 Phase 1 acquisition: SYNC_PAT split as h=F6 then next-cycle l=28 -> phase=1, lock, and data_out==16'hF628 on sof.
REQ-035 Loss of lock: in LOCK, corrupt 3 checkpoints then restore -> lock stays high and err_cnt=3. Corrupt 4 consecutive checkpoints -> lock falls after the 4th and err_cnt=7.
REQ-036 False sync: inject SYNC_PAT 512 cycles after the first detection, in VERIFY, with no sync at the checkpoint -> return to HUNT. The mid-frame pattern is ignored.
REQ-037 Controls: resync pulse in LOCK -> lock=0 next cycle, err_cnt held, reacquire. en=0 -> no lock. Assert rst_n=0 mid-frame -> all outputs 0 immediately, with no wait for an edge.
REQ-038 Saturation and priority: 300 misses across repeated locks -> err_cnt==255. Both w0 and w1 match in HUNT -> phase=0.

Source files
------------

// File: rtl/ddr_rx_align_ctrl.sv
// ddr_rx_align_ctrl: word aligner for a DDR input capture pair.
// Picks one of the two possible rising/falling-edge pairings by hunting for
// SYNC_PAT, confirms it at the frame period, then holds lock with miss tolerance.
// Ports:
//   inclock        capture clock, all registers on its rising edge
//   rst_n          asynchronous active-low reset
//   en             search enable; low forces HUNT and idle outputs
//   resync         one-cycle pulse forcing re-acquisition
//   ddr_h, ddr_l   rising / falling-edge samples (ddr_l is earlier in time)
//   data_out       aligned word, earliest bit in MSB, 1-cycle latency
//   data_vld, lock high while locked, aligned with data_out
//   sof            data_out holds SYNC_PAT at the frame position
//   phase          0 = {ddr_l,ddr_h}, 1 = {previous ddr_h,ddr_l}
//   err_cnt        saturating count of missed sync words while locked
module ddr_rx_align_ctrl #(
   parameter int                     PAD_WIDTH = 8,
   parameter logic [2*PAD_WIDTH-1:0] SYNC_PAT  = 16'hF628,
   parameter int                     FRAME_LEN = 1024,
   parameter int                     VERIFY_N  = 2,
   parameter int                     LOSS_N    = 4
)(
   input  logic                   inclock,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   resync,
   input  logic [PAD_WIDTH-1:0]   ddr_h,
   input  logic [PAD_WIDTH-1:0]   ddr_l,
   output logic [2*PAD_WIDTH-1:0] data_out,
   output logic                   data_vld,
   output logic                   sof,
   output logic                   lock,
   output logic                   phase,
   output logic [7:0]             err_cnt
);
   localparam int W  = 2*PAD_WIDTH;
   localparam int FW = $clog2(FRAME_LEN);
   typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;
   state_t state, state_n;
   logic [FW-1:0] fcnt, fcnt_n;
   logic [3:0] hcnt, hcnt_n, mcnt, mcnt_n;
   logic [PAD_WIDTH-1:0] h_d1;
   logic [7:0] err_n;
   logic [W-1:0] w0, w1, sel;
   logic phase_n, match, ckpt, stop, vld_n;
   assign w0    = {ddr_l, ddr_h};
   assign w1    = {h_d1, ddr_l};
   assign sel   = phase ? w1 : w0;
   assign match = sel == SYNC_PAT;
   assign stop  = !en || resync;
   assign ckpt  = state != HUNT && fcnt == '0;
   // outputs describe the current cycle, so a forced HUNT also idles them at once
   assign vld_n = state == LOCK && !stop;
   always_comb begin
      state_n = state;
      fcnt_n  = fcnt;
      hcnt_n  = hcnt;
      mcnt_n  = mcnt;
      phase_n = phase;
      err_n   = err_cnt;
      if (stop) begin
         state_n = HUNT;
         fcnt_n  = '0;
         hcnt_n  = '0;
         mcnt_n  = '0;
      end else if (state == HUNT) begin
         if (w0 == SYNC_PAT || w1 == SYNC_PAT) begin
            state_n = VERIFY;
            phase_n = w0 != SYNC_PAT;
            fcnt_n  = FW'(1);
            hcnt_n  = '0;
         end
      end else begin
         fcnt_n = (fcnt == FW'(FRAME_LEN - 1)) ? '0 : fcnt + 1'b1;
         if (ckpt && state == VERIFY) begin
            if (match) begin
               hcnt_n = hcnt + 4'd1;
               if (hcnt + 4'd1 == 4'(VERIFY_N)) state_n = LOCK;
            end else begin
               state_n = HUNT;
               fcnt_n  = '0;
            end
         end else if (ckpt) begin
            if (match) mcnt_n = '0;
            else begin
               mcnt_n = mcnt + 4'd1;
               err_n  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
               if (mcnt + 4'd1 == 4'(LOSS_N)) begin
                  state_n = HUNT;
                  fcnt_n  = '0;
                  mcnt_n  = '0;
               end
            end
         end
      end
   end
   always_ff @(posedge inclock or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         fcnt     <= '0;
         hcnt     <= '0;
         mcnt     <= '0;
         h_d1     <= '0;
         phase    <= 1'b0;
         err_cnt  <= '0;
         data_out <= '0;
         data_vld <= 1'b0;
         lock     <= 1'b0;
         sof      <= 1'b0;
      end else begin
         state    <= state_n;
         fcnt     <= fcnt_n;
         hcnt     <= hcnt_n;
         mcnt     <= mcnt_n;
         h_d1     <= ddr_h;
         phase    <= phase_n;
         err_cnt  <= err_n;
         data_out <= vld_n ? sel : '0;
         data_vld <= vld_n;
         lock     <= vld_n;
         sof      <= vld_n && ckpt && match;
      end
   end
endmodule

// File: tb/tb_ddr_rx_align_ctrl.sv
// tb_ddr_rx_align_ctrl: randomized check of two aligner instances against a frame-time reference model.
module tb_ddr_rx_align_ctrl;
   logic inclock = 1'b0;
   logic rst_n, en, resync;
   logic [7:0] ddr_h, ddr_l;
   logic [15:0] data_out0, data_out1;
   logic data_vld0, sof0, lock0, phase0, data_vld1, sof1, lock1, phase1;
   logic [7:0] err_cnt0, err_cnt1;
   logic [27:0] o0, o1;
   int fl [2] = '{16, 24};
   int vn [2] = '{2, 1};
   int ln [2] = '{4, 2};
   logic [15:0] pat [2] = '{16'hF628, 16'h5A5A};
   int mode [2], hits [2], miss [2], nchk [2];
   logic [7:0] errs [2];
   logic ph [2];
   logic [7:0] hprev;
   int cyc, nvec, nerr;
   logic [7:0] hs [2048];
   logic [7:0] ls [2048];
   always #5 inclock = ~inclock;
   ddr_rx_align_ctrl #(.FRAME_LEN(16)) u_dut0 (
      .inclock(inclock), .rst_n(rst_n), .en(en), .resync(resync),
      .ddr_h(ddr_h), .ddr_l(ddr_l), .data_out(data_out0), .data_vld(data_vld0),
      .sof(sof0), .lock(lock0), .phase(phase0), .err_cnt(err_cnt0));
   ddr_rx_align_ctrl #(.SYNC_PAT(16'h5A5A), .FRAME_LEN(24), .VERIFY_N(1), .LOSS_N(2)) u_dut1 (
      .inclock(inclock), .rst_n(rst_n), .en(en), .resync(resync),
      .ddr_h(ddr_h), .ddr_l(ddr_l), .data_out(data_out1), .data_vld(data_vld1),
      .sof(sof1), .lock(lock1), .phase(phase1), .err_cnt(err_cnt1));
   assign o0 = {data_out0, data_vld0, sof0, lock0, phase0, err_cnt0};
   assign o1 = {data_out1, data_vld1, sof1, lock1, phase1, err_cnt1};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         if (nerr <= 20) $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask
   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mode[k] = 0; hits[k] = 0; miss[k] = 0; nchk[k] = 0; errs[k] = 8'h0; ph[k] = 1'b0;
      end
      hprev = 8'h0;
   endtask
   // mode: 0 searching, 1 confirming, 2 locked; checkpoints are absolute cycle numbers
   task automatic model_step(input int k, input logic [15:0] w0, input logic [15:0] w1,
                             input logic e, input logic r, output logic [27:0] exp);
      logic [15:0] sel;
      logic m, ck, v, s;
      sel = ph[k] ? w1 : w0;
      m   = sel == pat[k];
      ck  = mode[k] != 0 && cyc == nchk[k];
      v   = e && !r && mode[k] == 2;
      s   = v && ck && m;
      if (!e || r) begin
         mode[k] = 0; hits[k] = 0; miss[k] = 0;
      end else if (mode[k] == 0) begin
         if (w0 == pat[k] || w1 == pat[k]) begin
            ph[k] = w0 != pat[k]; mode[k] = 1; hits[k] = 0; nchk[k] = cyc + fl[k];
         end
      end else if (ck) begin
         nchk[k] += fl[k];
         if (mode[k] == 1) begin
            if (m) begin
               hits[k]++;
               if (hits[k] == vn[k]) mode[k] = 2;
            end else mode[k] = 0;
         end else if (m) miss[k] = 0;
         else begin
            miss[k]++;
            if (errs[k] != 8'hFF) errs[k]++;
            if (miss[k] == ln[k]) begin
               mode[k] = 0; miss[k] = 0;
            end
         end
      end
      exp = {v ? sel : 16'h0, v, s, v, ph[k], errs[k]};
   endtask
   task automatic cycle(input logic [7:0] h, input logic [7:0] l, input logic e, input logic r);
      logic [27:0] e0, e1;
      @(negedge inclock);
      rst_n = 1'b1; ddr_h = h; ddr_l = l; en = e; resync = r;
      model_step(0, {l, h}, {hprev, l}, e, r, e0);
      model_step(1, {l, h}, {hprev, l}, e, r, e1);
      hprev = h;
      cyc++;
      @(posedge inclock);
      #1;
      chk("inst0", 32'(o0), 32'(e0));
      chk("inst1", 32'(o1), 32'(e1));
   endtask
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst0", 32'(o0), 32'h0);
      chk("async_rst1", 32'(o1), 32'h0);
      model_reset();
   endtask
   initial begin
      int seg, k, f, nfr, keep, len, c;
      logic seg_en, ph_s, did_rst;
      rst_n = 1'b0; en = 1'b0; resync = 1'b0; ddr_h = 8'h0; ddr_l = 8'h0;
      cyc = 0; nvec = 0; nerr = 0; seg = 0; did_rst = 1'b0;
      model_reset();
      repeat (3) @(posedge inclock);
      #1;
      chk("reset0", 32'(o0), 32'h0);
      chk("reset1", 32'(o1), 32'h0);
      while (cyc < 80000 && (seg < 12 || errs[0] != 8'hFF)) begin
         k      = ($urandom_range(0, 3) == 0) ? 1 : 0;
         f      = fl[k];
         ph_s   = 1'($urandom_range(0, 1));
         nfr    = $urandom_range(8, 40);
         keep   = $urandom_range(20, 95);
         seg_en = $urandom_range(0, 9) != 0;
         len    = nfr * f + 4;
         for (int i = 0; i < len; i++) begin
            hs[i] = 8'($urandom); ls[i] = 8'($urandom);
         end
         for (int fr = 0; fr < nfr; fr++) begin
            c = 2 + fr * f;
            if (fr < 3 || $urandom_range(0, 99) < keep) begin
               if (ph_s) begin hs[c-1] = pat[k][15:8]; ls[c] = pat[k][7:0]; end
               else begin ls[c] = pat[k][15:8]; hs[c] = pat[k][7:0]; end
            end
            if ($urandom_range(0, 7) == 0) begin
               ls[c + f/2] = pat[k][15:8]; hs[c + f/2] = pat[k][7:0];
            end
         end
         for (int i = 0; i < len; i++) begin
            cycle(hs[i], ls[i], seg_en && $urandom_range(0, 999) != 0, $urandom_range(0, 999) == 0);
            if (!did_rst && seg >= 5 && mode[0] == 2) begin
               do_reset();
               did_rst = 1'b1;
            end
         end
         seg++;
      end
      chk("err_sat", 32'(err_cnt0), 32'd255);
      cycle(8'h5A, 8'h00, 1'b1, 1'b1);
      cycle(8'h00, 8'h5A, 1'b1, 1'b0);
      chk("w1_only_phase", 32'(phase1), 32'd1);
      cycle(8'h5A, 8'h00, 1'b1, 1'b1);
      cycle(8'h5A, 8'h5A, 1'b1, 1'b0);
      chk("both_match_phase", 32'(phase1), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
